// File: rtl/mem_lsu_ysyx23060136_pkg.sv
// mem_lsu_ysyx23060136_pkg: FSM states, AXI response codes and access-size encoding shared by the LSU
package mem_lsu_ysyx23060136_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_DONE
  } lsu_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_BYTE_U,
    SZ_HALF_U
  } lsu_size_t;

  // One-hot size flags collapse to a code; no flag set falls back to a word access
  function automatic lsu_size_t size_enc(input logic b, input logic h, input logic w,
                                         input logic bu, input logic hu);
    return b ? SZ_BYTE : h ? SZ_HALF : w ? SZ_WORD : bu ? SZ_BYTE_U : hu ? SZ_HALF_U : SZ_WORD;
  endfunction

  function automatic logic misaligned(input lsu_size_t sz, input logic [1:0] off);
    return (sz == SZ_HALF || sz == SZ_HALF_U) ? off[0] : (sz == SZ_WORD) ? |off : 1'b0;
  endfunction

endpackage

// File: rtl/mem_lsu_ysyx23060136_align.sv
// mem_lsu_align_ysyx23060136: store lane replication/strobes and load lane extraction/extension
module mem_lsu_align_ysyx23060136
  import mem_lsu_ysyx23060136_pkg::*;
(
  input  lsu_size_t   st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  lsu_size_t   ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ld_data_o
);

  logic        st_b, st_h;
  logic [31:0] lane;

  always_comb begin
    st_b      = st_size_i == SZ_BYTE || st_size_i == SZ_BYTE_U;
    st_h      = st_size_i == SZ_HALF || st_size_i == SZ_HALF_U;
    wdata_o   = st_b ? {4{st_data_i[7:0]}} : st_h ? {2{st_data_i[15:0]}} : st_data_i;
    wstrb_o   = st_b ? 4'b0001 << st_off_i : st_h ? 4'b0011 << st_off_i : 4'b1111;
    lane      = ld_data_i >> {ld_off_i, 3'b000};
    ld_data_o = (ld_size_i == SZ_BYTE)   ? {{24{lane[7]}}, lane[7:0]} :
                (ld_size_i == SZ_BYTE_U) ? {24'b0, lane[7:0]} :
                (ld_size_i == SZ_HALF)   ? {{16{lane[15]}}, lane[15:0]} :
                (ld_size_i == SZ_HALF_U) ? {16'b0, lane[15:0]} : lane;
  end

endmodule

// File: rtl/mem_lsu_ysyx23060136.sv
// mem_lsu_ysyx23060136: MEM-stage load/store unit turning each instruction into at most one
// AXI4-Lite transaction and returning one aligned/extended result per instruction to WB.
module mem_lsu_ysyx23060136
  import mem_lsu_ysyx23060136_pkg::*;
#(
  parameter bit MISALIGN_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LSU_i_valid,
  output logic        LSU_o_ready,
  input  logic [31:0] LSU_i_addr,
  input  logic [31:0] LSU_i_wdata,
  input  logic        LSU_i_write_mem,
  input  logic        LSU_i_mem_to_reg,
  input  logic        LSU_i_mem_byte,
  input  logic        LSU_i_mem_half,
  input  logic        LSU_i_mem_word,
  input  logic        LSU_i_mem_byte_u,
  input  logic        LSU_i_mem_half_u,
  output logic        LSU_o_valid,
  input  logic        LSU_i_wb_ready,
  output logic [31:0] LSU_o_rdata,
  output logic        LSU_o_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  lsu_state_t  state_q, acc_state;
  lsu_size_t   size_q, in_size;
  logic [1:0]  off_q;
  logic [31:0] araddr_q, awaddr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        aw_done_q, w_done_q, valid_q, err_q;
  logic        accept, in_st, in_ld, in_mis;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wstrb;

  assign LSU_o_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & LSU_i_wb_ready);
  assign accept      = LSU_i_valid & LSU_o_ready;

  // A store flag wins over a load flag when both are set
  always_comb begin
    in_size   = size_enc(LSU_i_mem_byte, LSU_i_mem_half, LSU_i_mem_word,
                         LSU_i_mem_byte_u, LSU_i_mem_half_u);
    in_st     = LSU_i_write_mem;
    in_ld     = LSU_i_mem_to_reg & ~LSU_i_write_mem;
    in_mis    = MISALIGN_ERR && (in_st || in_ld) && misaligned(in_size, LSU_i_addr[1:0]);
    acc_state = in_mis ? S_DONE : in_st ? S_WR_REQ : in_ld ? S_RD_ADDR : S_DONE;
  end

  mem_lsu_align_ysyx23060136 u_align (
    .st_size_i (in_size),
    .st_off_i  (LSU_i_addr[1:0]),
    .st_data_i (LSU_i_wdata),
    .wdata_o   (st_wdata),
    .wstrb_o   (st_wstrb),
    .ld_size_i (size_q),
    .ld_off_i  (off_q),
    .ld_data_i (rdata),
    .ld_data_o (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      size_q    <= SZ_WORD;
      off_q     <= '0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      state_q   <= acc_state;
      size_q    <= in_size;
      off_q     <= LSU_i_addr[1:0];
      araddr_q  <= {LSU_i_addr[31:2], 2'b00};
      awaddr_q  <= {LSU_i_addr[31:2], 2'b00};
      wdata_q   <= st_wdata;
      wstrb_q   <= st_wstrb;
      arvalid_q <= acc_state == S_RD_ADDR;
      awvalid_q <= acc_state == S_WR_REQ;
      wvalid_q  <= acc_state == S_WR_REQ;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      valid_q   <= acc_state == S_DONE;
      rdata_q   <= '0;
      err_q     <= in_mis;
    end else begin
      case (state_q)
        S_RD_ADDR: if (arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= S_RD_DATA;
        end
        S_RD_DATA: if (rvalid) begin
          rready_q <= 1'b0;
          rdata_q  <= ld_data;
          err_q    <= rresp != AXI_RESP_OKAY;
          valid_q  <= 1'b1;
          state_q  <= S_DONE;
        end
        S_WR_REQ: begin
          if (awready) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (wready) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q | awready) & (w_done_q | wready)) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: if (bvalid) begin
          bready_q <= 1'b0;
          err_q    <= bresp != AXI_RESP_OKAY;
          valid_q  <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: if (LSU_i_wb_ready) begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign araddr      = araddr_q;
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;
  assign awaddr      = awaddr_q;
  assign awvalid     = awvalid_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign wvalid      = wvalid_q;
  assign bready      = bready_q;
  assign LSU_o_valid = valid_q;
  assign LSU_o_rdata = rdata_q;
  assign LSU_o_err   = err_q;

endmodule

// File: doc/mem_lsu_ysyx23060136.md
Name: mem_lsu_ysyx23060136

Overview:
- Load/store unit at the head of the MEM stage. It is the consumer of the EXU memory-side outputs: ALU result used as the address, forwarded rs2 data, size and sign flags, write_mem and mem_to_reg.
- Converts each accepted instruction into at most one AXI4-Lite master transaction.
- Aligns and extends load data, then hands one result per instruction to WB over a valid/ready handshake.
- Non-memory instructions pass through with no bus activity.

Parameters:
- MISALIGN_ERR, default 1: 1 = misaligned access is flagged as an error and no bus transaction is issued; 0 = the access is issued at the word-aligned address with no error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- LSU_i_valid  in  1  instruction from EXU valid
- LSU_o_ready  out  1  LSU can accept an instruction
- LSU_i_addr  in  32  byte address (EXU ALU result)
- LSU_i_wdata  in  32  store data (forwarded rs2)
- LSU_i_write_mem  in  1  store
- LSU_i_mem_to_reg  in  1  load
- LSU_i_mem_byte / _half / _word / _byte_u / _half_u  in  1 each  one-hot access size and signedness
- LSU_o_valid  out  1  result valid to WB
- LSU_i_wb_ready  in  1  WB accepts result
- LSU_o_rdata  out  32  extended load data; 0 for stores and non-memory instructions
- LSU_o_err  out  1  misalignment or nonzero RRESP/BRESP
- araddr out 32, arvalid out 1, arready in 1
- rdata in 32, rresp in 2, rvalid in 1, rready out 1
- awaddr out 32, awvalid out 1, awready in 1
- wdata out 32, wstrb out 4, wvalid out 1, wready in 1
- bresp in 2, bvalid in 1, bready out 1

Behaviour:
- Reset (async, active-high): FSM=IDLE. All AXI valid/ready outputs 0. LSU_o_valid=0, LSU_o_rdata=0, LSU_o_err=0, all address/data/strobe registers 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Upstream handshake:
  - LSU_o_ready = (IDLE) | (DONE & LSU_i_wb_ready).
  - An instruction is accepted when LSU_i_valid & LSU_o_ready.
  - On accept, address, data, size flags and load/store type are latched; inputs are not sampled afterwards.
- Next state on accept:
  - Misaligned and MISALIGN_ERR=1 → DONE, err=1, rdata=0. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - Load → RD_ADDR.
  - Store → WR_REQ.
  - Neither load nor store → DONE, rdata=0, err=0.
  - write_mem and mem_to_reg both set: treat as a store.
- Bus address: araddr/awaddr = {addr[31:2], 2'b00}, held constant until the address handshake completes.
- RD_ADDR: arvalid=1; stays asserted until arready. On arvalid & arready → RD_DATA.
- RD_DATA:
  - rready=1. On rvalid → DONE.
  - Lane = rdata >> (8*addr[1:0]).
  - byte → sign-extend [7:0]; byte_u → zero-extend [7:0]; half → sign-extend [15:0]; half_u → zero-extend [15:0]; word → as is.
  - err = (rresp≠0).
- WR_REQ:
  - awvalid and wvalid both assert on entry.
  - Each deasserts independently after its own handshake. The completion of each is tracked by an internal flag.
  - → WR_RESP in the cycle in which both handshakes are complete; this includes both completing in the same cycle.
- Write data and strobes:
  - wdata: byte → {4{d[7:0]}}; half → {2{d[15:0]}}; word → d.
  - wstrb: byte → 4'b0001 << addr[1:0]; half → 4'b0011 << addr[1:0]; word → 4'b1111.
- WR_RESP: bready=1. On bvalid → DONE, err = (bresp≠0).
- DONE:
  - LSU_o_valid=1. rdata and err are held stable until LSU_i_wb_ready.
  - On handshake: if a new instruction is accepted in the same cycle, branch exactly as from IDLE; otherwise → IDLE.
- Throughput and latency:
  - Non-memory back-to-back instructions: one per cycle while in DONE with wb_ready high.
  - Minimum load latency, accept to o_valid: 3 cycles (IDLE→RD_ADDR→RD_DATA→DONE with zero-wait slave).
- AXI rules:
  - No valid signal depends combinationally on the matching ready.
  - Once asserted, a valid is never dropped before its handshake.
  - No timeout.
- Mid-transaction reset: all valids drop asynchronously and the FSM returns to IDLE. Bus-side recovery is the system reset's responsibility.

Decomposition:
- Shared package (DEFINES_ysyx23060136.sv): state enum lsu_state_t, AXI_RESP_OKAY=2'b00, size-encoding constants.
- One natural sub-module: mem_lsu_align_ysyx23060136. Combinational; builds wstrb/wdata for stores and extracts/extends load data. Unit-tested standalone.

Test Plan:
- lb at addr 0x8000_0003, slave rdata 0x80FF_1234, zero-wait → araddr 0x8000_0000, o_rdata 0xFFFF_FF80, err=0, o_valid 3 cycles after accept.
- sh data 0x0000_ABCD at 0x8000_0002, awready 2 cycles before wready → wdata 0xABCD_ABCD, wstrb 4'b1100, awvalid drops first, single bready handshake, o_valid with rdata=0.
- lw at 0x8000_0001, MISALIGN_ERR=1 → no arvalid ever, o_valid next cycle with err=1.
- lhu at 0x8000_0002 with rresp=2'b10 and rdata 0xBEEF_0000 → o_rdata 0x0000_BEEF, err=1.
- Three back-to-back ALU ops with wb_ready held low 2 cycles on the first → o_rdata/o_valid stable while stalled, LSU_o_ready=0, then one result per cycle.
- rst asserted while in WR_REQ with awvalid=1 → awvalid and wvalid 0 in the same cycle, FSM in IDLE, LSU_o_ready=1 after release.
